// File: rtl/tile_sequencer_if.sv
// Player-side bus of the tile sequencer: start/random/button inputs plus playfield, score and status outputs.
interface tile_sequencer_if #(
    parameter int ROWS    = 4,
    parameter int SCORE_W = 10
);
    logic                 start;
    logic [2:0]           ran;
    logic [3:0]           btn;
    logic [4*ROWS-1:0]    rows;
    logic                 state_change;
    logic [SCORE_W-1:0]   score;
    logic [3:0]           level;
    logic                 playing;
    logic                 game_over;
    logic [1:0]           lives;

    modport master (
        output start, ran, btn,
        input  rows, state_change, score, level, playing, game_over, lives
    );

    modport slave (
        input  start, ran, btn,
        output rows, state_change, score, level, playing, game_over, lives
    );
endinterface

// File: rtl/tile_sequencer.sv
// Tile game controller: scroll timer, lane queue, scoring and IDLE/RUN/OVER flow.
// Optional LIVES_EN macro gives three lives per game instead of a single one.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | game in progress, timer scrolling rows
//   OVER  | game ended, outputs frozen until start
module tile_sequencer #(
    parameter int ROWS       = 4,
    parameter int TICK_INIT  = 25000000,
    parameter int TICK_STEP  = 2000000,
    parameter int TICK_MIN   = 5000000,
    parameter int LEVEL_HITS = 8,
    parameter int SCORE_W    = 10
) (
    input logic             clk,
    input logic             rst_n,
    tile_sequencer_if.slave bus
);
    localparam int RW = 4 * ROWS;
    localparam int HW = $clog2(LEVEL_HITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      rows_q;
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         level_q;
    logic [HW-1:0]      hit_cnt;
    logic [25:0]        cnt, period, period_cur, period_nxt;
    logic               sc_q;

    logic [3:0] row0, new_top;
    logic       running, onehot, hit, wrong, tick, miss, fail, lvl_up, last_life;

    assign running = (state == RUN);
    assign row0    = rows_q[3:0];
    assign onehot  = (bus.btn != 4'd0) && ((bus.btn & (bus.btn - 4'd1)) == 4'd0);
    assign hit     = running && onehot && (bus.btn == row0);
    assign wrong   = running && (bus.btn != 4'd0) && !hit;
    assign tick    = running && (cnt == period_cur - 26'd1);
    // a same-cycle hit clears row 0 before the tick looks at it
    assign miss    = tick && !hit && (row0 != 4'd0);
    assign fail    = wrong || miss;
    assign lvl_up  = hit && (hit_cnt == HW'(LEVEL_HITS - 1));
    assign new_top = bus.ran[2] ? 4'b0000 : (4'b1000 >> bus.ran[1:0]);

    always_comb begin
        period_nxt = period;
        if (lvl_up)
            period_nxt = (period >= 26'(TICK_MIN + TICK_STEP)) ? period - 26'(TICK_STEP)
                                                                : 26'(TICK_MIN);
    end

`ifdef LIVES_EN
    logic [1:0] lives_q;

    assign last_life = (lives_q == 2'd1);
    assign bus.lives = lives_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lives_q <= 2'd3;
        else if (!running && bus.start)
            lives_q <= 2'd3;
        else if (fail)
            lives_q <= lives_q - 2'd1;
    end
`else
    assign last_life = 1'b1;
    assign bus.lives = 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (fail && last_life) state_nxt = OVER;
            OVER:    if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_q     <= '0;
            score_q    <= '0;
            level_q    <= 4'd0;
            hit_cnt    <= '0;
            cnt        <= 26'd0;
            period     <= 26'(TICK_INIT);
            period_cur <= 26'(TICK_INIT);
            sc_q       <= 1'b0;
        end else begin
            sc_q <= 1'b0;
            if (!running) begin
                if (bus.start) begin
                    rows_q     <= '0;
                    score_q    <= '0;
                    level_q    <= 4'd0;
                    hit_cnt    <= '0;
                    cnt        <= 26'd0;
                    period     <= 26'(TICK_INIT);
                    period_cur <= 26'(TICK_INIT);
                end
            end else if (!(fail && last_life)) begin
                if (hit) begin
                    if (score_q != {SCORE_W{1'b1}})
                        score_q <= score_q + SCORE_W'(1);
                    hit_cnt <= lvl_up ? '0 : hit_cnt + HW'(1);
                    if (lvl_up && level_q != 4'hF)
                        level_q <= level_q + 4'd1;
                    period <= period_nxt;
                end
                // a shortened period only takes effect at the next wrap
                if (tick) begin
                    rows_q     <= {new_top, rows_q[RW-1:4]};
                    cnt        <= 26'd0;
                    period_cur <= period_nxt;
                    sc_q       <= 1'b1;
                end else begin
                    cnt <= cnt + 26'd1;
                    if (hit)
                        rows_q[3:0] <= 4'd0;
                end
            end
        end
    end

    assign bus.rows         = rows_q;
    assign bus.state_change = sc_q;
    assign bus.score        = score_q;
    assign bus.level        = level_q;
    assign bus.playing      = running;
    assign bus.game_over    = (state == OVER);
endmodule
